// File: rtl/digi_sampler_if.sv
// CPU cartridge IO bus as seen by the sampler: address, strobes, data and IRQ.
interface digi_sampler_if;
  logic [15:0] addr;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        irq_n;

  // CPU side drives the bus, the cartridge answers.
  modport master (
    output addr, rd_n, wr_n, data_in,
    input  data_out, data_oe, irq_n
  );

  modport slave (
    input  addr, rd_n, wr_n, data_in,
    output data_out, data_oe, irq_n
  );
endinterface

// File: rtl/digi_sampler.sv
// Sampler cartridge: decimates a PCM stream into a small FIFO that the CPU
// drains through IO1 ($DE00-$DE03).
module digi_sampler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic           clk,
  input  logic           reset,
  digi_sampler_if.slave  bus,
  input  logic [15:0]    audio_in,
  input  logic           audio_valid
);

  localparam logic [13:0] IoBase    = 14'h3780;
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] HalfCount = (AW+1)'(DEPTH / 2);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    div_q, div_d, ctrl_q, ctrl_d, dcnt_q, dcnt_d, data_out_q, data_out_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, acc_q;

  logic       hit, acc, first, rd_first, wr_first;
  logic [1:0] reg_sel;
  logic       full, empty, flush, pop_req, push_req, do_pop, do_push;
  logic       ovf_set, unf_set, stat_rd, div_wr, ctrl_wr;
  logic [7:0] status, rd_data;
  logic       unused_audio;

  assign unused_audio = ^audio_in[7:0];

  // Only the first cycle of a held strobe counts as a new access.
  assign hit      = bus.addr[15:2] == IoBase;
  assign acc      = (!bus.rd_n || !bus.wr_n) && hit;
  assign first    = acc && !acc_q;
  assign rd_first = first && !bus.rd_n;
  assign wr_first = first && bus.rd_n && !bus.wr_n;
  assign reg_sel  = bus.addr[1:0];

  assign full    = count_q == FullCount;
  assign empty   = count_q == '0;
  assign div_wr  = wr_first && (reg_sel == 2'd2);
  assign ctrl_wr = wr_first && (reg_sel == 2'd3);
  assign flush   = ctrl_wr && bus.data_in[1];
  assign stat_rd = rd_first && (reg_sel == 2'd1);
  assign pop_req = rd_first && (reg_sel == 2'd0);

  assign push_req = audio_valid && ctrl_q[0] && (dcnt_q == div_q);
  assign do_pop   = pop_req && !empty && !flush;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign do_push  = push_req && (!full || do_pop) && !flush;
  assign ovf_set  = push_req && full && !do_pop && !flush;
  assign unf_set  = pop_req && empty;

  // At DEPTH entries the count field wraps to zero; FULL carries the information.
  assign status = {full, empty, ovf_q, unf_q, 4'(count_q[AW-1:0])};

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = !reset && !bus.rd_n && hit;
  assign bus.irq_n    = !(ctrl_q[2] && (count_q >= HalfCount));

  // Register read mux.
  always_comb begin
    rd_data = 8'h80;
    unique case (reg_sel)
      2'd0:    rd_data = empty ? 8'h80 : mem_q[rd_ptr_q];
      2'd1:    rd_data = status;
      2'd2:    rd_data = div_q;
      default: rd_data = ctrl_q;
    endcase
  end

  // Next-state for FIFO, registers, flags and decimation counter.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    div_d      = div_q;
    ctrl_d     = ctrl_q;
    dcnt_d     = dcnt_q;
    data_out_d = data_out_q;
    ovf_d      = (ovf_q && !stat_rd) || ovf_set;
    unf_d      = (unf_q && !stat_rd) || unf_set;

    if (rd_first) data_out_d = rd_data;
    if (div_wr)   div_d = bus.data_in;
    if (ctrl_wr)  ctrl_d = bus.data_in & 8'hFD;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    if (div_wr || !ctrl_q[0]) begin
      dcnt_d = '0;
    end else if (audio_valid) begin
      dcnt_d = push_req ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  // Control/status state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      div_q      <= '0;
      ctrl_q     <= '0;
      dcnt_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      data_out_q <= 8'h80;
    end else begin
      acc_q      <= acc;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      dcnt_q     <= dcnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      data_out_q <= data_out_d;
    end
  end

  // Sample storage, kept as the unsigned byte the CPU reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= audio_in[15:8] ^ 8'h80;
  end

endmodule

// File: tb/tb_digi_sampler.sv
// Directed bench for digi_sampler: decimation, FIFO, flags, IRQ and reset.
module tb_digi_sampler;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] audio_in;
  logic        audio_valid;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  rdat;

  digi_sampler_if bus ();

  digi_sampler #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .audio_in    (audio_in),
    .audio_valid (audio_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.rd_n = 1'b0;
    @(posedge clk);
    #1 d = bus.data_out;
    @(negedge clk);
    bus.rd_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr    = a;
    bus.data_in = d;
    bus.wr_n    = 1'b0;
    @(negedge clk);
    bus.wr_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic push(input logic [15:0] s);
    @(negedge clk);
    audio_in    = s;
    audio_valid = 1'b1;
    @(negedge clk);
    audio_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    audio_in    = '0;
    audio_valid = 1'b0;
    bus.addr    = '0;
    bus.rd_n    = 1'b1;
    bus.wr_n    = 1'b1;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", bus.data_out, 8'h80);
    check("rst_data_oe", {7'd0, bus.data_oe}, 8'h00);
    check("rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    cpu_read(16'hDE01, rdat); check("rst_status", rdat, 8'h40);

    // Basic capture and pop, then underflow.
    cpu_write(16'hDE03, 8'h01);
    push(16'h1234); push(16'hF000); push(16'h0000);
    cpu_read(16'hDE00, rdat); check("pop0", rdat, 8'h92);
    cpu_read(16'hDE00, rdat); check("pop1", rdat, 8'h70);
    cpu_read(16'hDE00, rdat); check("pop2", rdat, 8'h80);
    cpu_read(16'hDE00, rdat); check("pop_empty", rdat, 8'h80);
    cpu_read(16'hDE01, rdat); check("status_unf", rdat, 8'h50);
    cpu_read(16'hDE01, rdat); check("status_unf_clr", rdat, 8'h40);

    // Decimation by DIV+1.
    cpu_write(16'hDE02, 8'h03);
    for (int i = 0; i < 40; i++) push(16'h4000);
    cpu_read(16'hDE01, rdat); check("decim_count", rdat, 8'h0A);
    check("irq_disabled", {7'd0, bus.irq_n}, 8'h01);
    cpu_read(16'hDE02, rdat); check("div_read", rdat, 8'h03);

    // Flush, FLUSH bit reads back 0.
    cpu_write(16'hDE03, 8'h03);
    cpu_read(16'hDE03, rdat); check("ctrl_read", rdat, 8'h01);
    cpu_read(16'hDE01, rdat); check("flush_empty", rdat, 8'h40);
    cpu_write(16'hDE02, 8'h00);

    // Overflow: 17 pushes, the last dropped.
    for (int i = 0; i < 17; i++) push({8'h10 + 8'(i), 8'h00});
    cpu_read(16'hDE01, rdat); check("full_ovf", rdat, 8'hA0);
    cpu_read(16'hDE01, rdat); check("full_ovf_clr", rdat, 8'h80);

    // Push and pop together while full: no overflow.
    @(negedge clk);
    bus.addr = 16'hDE00; bus.rd_n = 1'b0;
    audio_in = 16'h5500; audio_valid = 1'b1;
    @(posedge clk);
    #1 check("coinc_pop", bus.data_out, 8'h90);
    @(negedge clk);
    audio_valid = 1'b0; bus.rd_n = 1'b1;
    @(posedge clk);
    cpu_read(16'hDE01, rdat); check("coinc_status", rdat, 8'h80);

    // Long-held read pops exactly once.
    @(negedge clk);
    bus.addr = 16'hDE00; bus.rd_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("hold_data", bus.data_out, 8'h91);
    end
    check("hold_oe", {7'd0, bus.data_oe}, 8'h01);
    @(negedge clk);
    bus.rd_n = 1'b1;
    @(posedge clk);
    cpu_read(16'hDE01, rdat); check("hold_count", rdat, 8'h0F);
    cpu_read(16'hDE00, rdat); check("after_hold", rdat, 8'h92);
    for (int i = 3; i < 16; i++) begin
      cpu_read(16'hDE00, rdat); check("drain", rdat, (8'h10 + 8'(i)) ^ 8'h80);
    end
    cpu_read(16'hDE00, rdat); check("drain_coinc", rdat, 8'hD5);
    cpu_read(16'hDE00, rdat); check("drain_empty", rdat, 8'h80);
    cpu_read(16'hDE01, rdat); check("drain_status", rdat, 8'h50);

    // IRQ: flush in the same write that enables IRQ.
    for (int i = 0; i < 9; i++) push(16'h2000);
    cpu_write(16'hDE03, 8'h07);
    check("irq_after_flush", {7'd0, bus.irq_n}, 8'h01);
    for (int i = 0; i < 7; i++) push(16'h2000);
    check("irq_at_7", {7'd0, bus.irq_n}, 8'h01);
    push(16'h2000);
    check("irq_at_8", {7'd0, bus.irq_n}, 8'h00);

    // Reset in the middle of a held read.
    @(negedge clk);
    bus.addr = 16'hDE01; bus.rd_n = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_read", bus.data_out, 8'h08);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", bus.data_out, 8'h80);
    check("mid_rst_oe", {7'd0, bus.data_oe}, 8'h00);
    check("mid_rst_irq", {7'd0, bus.irq_n}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("held_not_new", bus.data_out, 8'h80);
    @(negedge clk);
    bus.rd_n = 1'b1;
    @(posedge clk);
    cpu_read(16'hDE01, rdat); check("post_rst_status", rdat, 8'h40);
    cpu_read(16'hDE03, rdat); check("post_rst_ctrl", rdat, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
